// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: latches the fetched instruction and PC, exposes decode
// fields as slices of the held word, and counts consecutive hazard stalls.
module if_id_pipe #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned SCNT_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [31:0]       inst_i,
    input  logic              valid_i,
    input  logic              hd_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [ADDR_W-1:0] imm_sext_o,
    output logic [25:0]       jtarget_o,
    output logic [SCNT_W-1:0] stall_cnt_o,
    output logic              stall_sat_o
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [SCNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    logic              r_valid;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pc4;
    logic [SCNT_W-1:0] r_cnt;

    state_t            w_state;
    logic              w_valid;
    logic [31:0]       w_inst;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_pc4;
    logic [SCNT_W-1:0] w_cnt;

    // Next-state and next-data: flush beats stall beats load.
    always_comb begin
        w_state = r_state;
        w_valid = r_valid;
        w_inst  = r_inst;
        w_addr  = r_addr;
        w_pc4   = r_pc4;
        w_cnt   = r_cnt;

        case (r_state)
            ST_RUN:   if (hd_i && !flush_i) w_state = ST_STALL;
            ST_STALL: if (!hd_i || flush_i) w_state = ST_RUN;
            default:  w_state = ST_RUN;
        endcase

        if (flush_i) begin
            w_valid = 1'b0;
            w_inst  = NOP_INST;
            w_addr  = '0;
            w_pc4   = '0;
            w_cnt   = '0;
        end else if (hd_i) begin
            if (r_cnt != CNT_MAX) w_cnt = r_cnt + SCNT_W'(1);
        end else begin
            w_valid = valid_i;
            w_inst  = valid_i ? inst_i : NOP_INST;
            w_addr  = inst_addr_i;
            w_pc4   = inst_addr_i + ADDR_W'(4);
            w_cnt   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_addr  <= '0;
            r_pc4   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_valid <= w_valid;
            r_inst  <= w_inst;
            r_addr  <= w_addr;
            r_pc4   <= w_pc4;
            r_cnt   <= w_cnt;
        end
    end

    assign valid_o     = r_valid;
    assign inst_o      = r_inst;
    assign inst_addr_o = r_addr;
    assign pc_plus4_o  = r_pc4;
    assign op_o        = r_inst[31:26];
    assign funct_o     = r_inst[5:0];
    assign rs_o        = r_inst[25:21];
    assign rt_o        = r_inst[20:16];
    assign rd_o        = r_inst[15:11];
    assign imm_sext_o  = ADDR_W'($signed(r_inst[15:0]));
    assign jtarget_o   = r_inst[25:0];
    assign stall_cnt_o = r_cnt;
    assign stall_sat_o = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: two instances (8-bit and 2-bit stall counters)
// share stimulus; a transaction-level model predicts each cycle's outputs.
module tb_if_id_pipe;

    localparam int unsigned AW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_i = '0;
    logic        valid_i = 1'b0;
    logic        hd_i = 1'b0;
    logic        flush_i = 1'b0;

    logic        a_valid, b_valid;
    logic [31:0] a_inst, b_inst, a_addr, b_addr, a_pc4, b_pc4, a_imm, b_imm;
    logic [5:0]  a_op, b_op, a_funct, b_funct;
    logic [4:0]  a_rs, b_rs, a_rt, b_rt, a_rd, b_rd;
    logic [25:0] a_jt, b_jt;
    logic [7:0]  a_cnt;
    logic [1:0]  b_cnt;
    logic        a_sat, b_sat;

    always #5 clk_i = ~clk_i;

    if_id_pipe #(.ADDR_W(32), .NOP_INST(NOP), .SCNT_W(8)) dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .inst_addr_i(inst_addr_i), .inst_i(inst_i),
        .valid_i(valid_i), .hd_i(hd_i), .flush_i(flush_i),
        .valid_o(a_valid), .inst_o(a_inst), .inst_addr_o(a_addr), .pc_plus4_o(a_pc4),
        .op_o(a_op), .funct_o(a_funct), .rs_o(a_rs), .rt_o(a_rt), .rd_o(a_rd),
        .imm_sext_o(a_imm), .jtarget_o(a_jt), .stall_cnt_o(a_cnt), .stall_sat_o(a_sat)
    );

    if_id_pipe #(.ADDR_W(32), .NOP_INST(NOP), .SCNT_W(2)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .inst_addr_i(inst_addr_i), .inst_i(inst_i),
        .valid_i(valid_i), .hd_i(hd_i), .flush_i(flush_i),
        .valid_o(b_valid), .inst_o(b_inst), .inst_addr_o(b_addr), .pc_plus4_o(b_pc4),
        .op_o(b_op), .funct_o(b_funct), .rs_o(b_rs), .rt_o(b_rt), .rd_o(b_rd),
        .imm_sext_o(b_imm), .jtarget_o(b_jt), .stall_cnt_o(b_cnt), .stall_sat_o(b_sat)
    );

    typedef struct {
        bit              valid;
        longint unsigned inst;
        longint unsigned addr;
        longint unsigned pc4;
        longint unsigned run;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;

    // Model state: the whole pipeline register plus the unbounded stall run length.
    bit              m_valid = 0;
    longint unsigned m_inst = 0, m_addr = 0, m_pc4 = 0, m_run = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic longint unsigned min_ul(longint unsigned a, longint unsigned b);
        return (a < b) ? a : b;
    endfunction

    // Drive one cycle of inputs at the falling edge and record the predicted result.
    task automatic step(input bit rst, input bit v, input bit hd, input bit fl,
                        input logic [31:0] addr, input logic [31:0] ins);
        exp_t e;
        @(negedge clk_i);
        rst_i = rst; valid_i = v; hd_i = hd; flush_i = fl;
        inst_addr_i = addr; inst_i = ins;
        if (rst || fl) begin
            m_valid = 0; m_inst = NOP; m_addr = 0; m_pc4 = 0; m_run = 0;
        end else if (hd) begin
            m_run = m_run + 1;
        end else begin
            m_valid = v;
            m_inst  = v ? longint'(ins) : longint'(NOP);
            m_addr  = addr;
            m_pc4   = (longint'(addr) + 4) % 64'h1_0000_0000;
            m_run   = 0;
        end
        e.valid = m_valid; e.inst = m_inst; e.addr = m_addr; e.pc4 = m_pc4; e.run = m_run;
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #2;
    endtask

    // Monitor: one prediction per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        longint unsigned imm;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                imm = e.inst % 65536;
                if (imm >= 32768) imm = imm + 64'hFFFF_0000;
                chk("valid",   a_valid, e.valid);
                chk("inst",    a_inst,  e.inst);
                chk("addr",    a_addr,  e.addr);
                chk("pc4",     a_pc4,   e.pc4);
                chk("op",      a_op,    e.inst / (1 << 26));
                chk("funct",   a_funct, e.inst % 64);
                chk("rs",      a_rs,    (e.inst / (1 << 21)) % 32);
                chk("rt",      a_rt,    (e.inst / (1 << 16)) % 32);
                chk("rd",      a_rd,    (e.inst / (1 << 11)) % 32);
                chk("imm",     a_imm,   imm);
                chk("jtarget", a_jt,    e.inst % (1 << 26));
                chk("cnt8",    a_cnt,   min_ul(e.run, 255));
                chk("sat8",    a_sat,   (e.run >= 255) ? 1 : 0);
                chk("cnt2",    b_cnt,   min_ul(e.run, 3));
                chk("sat2",    b_sat,   (e.run >= 3) ? 1 : 0);
                chk("valid2",  b_valid, e.valid);
                chk("pc4_2",   b_pc4,   e.pc4);
            end
        end
    end

    initial begin
        int waited;
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 0, 32'h1234, 32'hDEAD_BEEF);
        after_edge();
        chk("rst_valid", a_valid, 0);
        chk("rst_cnt", a_cnt, 0);

        // Basic load of lw r2,4(r1)
        step(0, 1, 0, 0, 32'h100, 32'h8C22_0004);
        after_edge();
        chk("ld_op", a_op, 6'h23);
        chk("ld_rs", a_rs, 1);
        chk("ld_rt", a_rt, 2);
        chk("ld_imm", a_imm, 4);
        chk("ld_pc4", a_pc4, 32'h104);
        chk("ld_valid", a_valid, 1);

        // Three stalls with changing inputs, then a load
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, $urandom, $urandom);
            after_edge();
            chk("stl_cnt", a_cnt, i + 1);
            chk("stl_hold", a_inst, 32'h8C22_0004);
        end
        step(0, 1, 0, 0, 32'h200, 32'h0123_4567);
        after_edge();
        chk("stl_rel_cnt", a_cnt, 0);
        chk("stl_rel_inst", a_inst, 32'h0123_4567);

        // Flush together with stall
        step(0, 1, 1, 0, 32'h300, 32'h1111_1111);
        step(0, 1, 1, 1, 32'h304, 32'h2222_2222);
        after_edge();
        chk("fl_valid", a_valid, 0);
        chk("fl_inst", a_inst, NOP);
        chk("fl_cnt", a_cnt, 0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 6; i++) begin
            step(0, $urandom_range(0, 1), 1, 0, $urandom, $urandom);
            after_edge();
            chk("sat_cnt2", b_cnt, (i < 3) ? i + 1 : 3);
            chk("sat_flag2", b_sat, (i >= 2) ? 1 : 0);
        end
        step(0, 0, 0, 0, 32'h0, $urandom);

        // PC wrap and negative immediate
        step(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h2001_8000);
        after_edge();
        chk("wrap_pc4", a_pc4, 0);
        chk("sext_imm", a_imm, 32'hFFFF_8000);

        // Bubble stalls still count; reset mid-stall
        step(0, 0, 0, 0, 32'h400, $urandom);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, $urandom, $urandom);
        after_edge();
        chk("bub_cnt", a_cnt, 5);
        chk("bub_inst", a_inst, NOP);
        step(1, 1, 1, 1, 32'h500, 32'hFFFF_FFFF);
        after_edge();
        chk("rst_stl_cnt", a_cnt, 0);
        chk("rst_stl_pc4", a_pc4, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 8),
                 $urandom, $urandom);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk_i);
            waited++;
        end
        #3;
        if (exp_q.size() > 0) chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
